sw_debounce: RTL and testbench



---
 rtl/sw_debounce.sv | 81 ++++++++
 tb/tb_sw_debounce.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser on every raw switch bit, followed by a
// single shared stability counter. Registered stable levels are published
// only after all bits have held still for STABLE_CNT cycles, together with
// one-cycle rise/fall pulses on the update edge.
module sw_debounce #(
  parameter int N_IN       = 16,
  parameter int STABLE_CNT = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] sw_raw,
  output logic [N_IN-1:0] sw_db,
  output logic [N_IN-1:0] sw_rise,
  output logic [N_IN-1:0] sw_fall,
  output logic            busy
);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_IN-1:0]  sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  db_q, db_d;
  logic [N_IN-1:0]  rise_q, rise_d;
  logic [N_IN-1:0]  fall_q, fall_d;

  // Synchroniser chain plus one-cycle history used for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Stability window: any change restarts it; the final count publishes the
  // synchronised value and the edge pulses, then the counter saturates.
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = CNT_SAT;
      db_d   = sync2_q;
      rise_d = sync2_q & ~db_q;
      fall_d = ~sync2_q & db_q;
    end else if (cnt_q < CNT_LAST) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Filter state and registered outputs; reset leaves the counter saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT_SAT;
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sw_db   = db_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
  assign busy    = (cnt_q != CNT_SAT);

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with STABLE_CNT=8, N_IN=4. A timestamp-based model
// (edge index of the last synchronised change) predicts every output on
// every edge; a vector table and hand sequences add fixed expectations.
module tb_sw_debounce;

  localparam int N = 4;
  localparam int S = 8;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] raw;
  logic [N-1:0] db, rise, fall;
  logic         busy;

  int checks = 0;
  int fails  = 0;

  sw_debounce #(.N_IN(N), .STABLE_CNT(S), .CNT_W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_raw  (raw),
    .sw_db   (db),
    .sw_rise (rise),
    .sw_fall (fall),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: q holds the raw samples taken at the last three edges (oldest
  // first); an update is due exactly S edges after the last detected change.
  logic [N-1:0] q[$];
  longint       edge_n;
  longint       chg;
  bit           pending;
  logic [N-1:0] m_db, m_rise, m_fall;
  logic         m_busy;

  typedef struct {
    logic [N-1:0] raw;
    int unsigned  n;
    logic [N-1:0] db;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         busy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q = '{'0, '0, '0};
    edge_n  = 0;
    chg     = 0;
    pending = 1'b0;
    m_db    = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_busy  = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] sample);
    edge_n++;
    m_rise = '0;
    m_fall = '0;
    if (q[1] != q[0]) begin
      chg     = edge_n;
      pending = 1'b1;
    end else if (pending && edge_n == chg + S) begin
      m_rise  = q[1] & ~m_db;
      m_fall  = ~q[1] & m_db;
      m_db    = q[1];
      pending = 1'b0;
    end
    m_busy = pending;
    q.push_back(sample);
    void'(q.pop_front());
  endtask

  // One clock edge: model advances with the value the DUT sampled, outputs
  // are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step(raw);
    #1;
    check("model.db",   db,   m_db);
    check("model.rise", rise, m_rise);
    check("model.fall", fall, m_fall);
    check("model.busy", {3'b000, busy}, {3'b000, m_busy});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".db"},   db,   '0);
    check({tag, ".rise"}, rise, '0);
    check({tag, ".fall"}, fall, '0);
    check({tag, ".busy"}, {3'b000, busy}, 4'b0000);
  endtask

  // Asynchronous reset asserted mid-cycle, held for a few edges.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1 check_cleared("rst.async");
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_cleared("rst.hold");
    end
    rst = 1'b0;
  endtask

  initial begin
    int rise_cnt;
    rst = 1'b1;
    raw = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Basic latency, simultaneous rise/fall, glitch, staggered restart.
    tbl.push_back('{4'b0001,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    tbl.push_back('{4'b0001,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    tbl.push_back('{4'b0001,  1, 4'b0000, 4'b0000, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001,  7, 4'b0000, 4'b0000, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001,  1, 4'b0001, 4'b0001, 4'b0000, 1'b0});
    tbl.push_back('{4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 1'b0});
    tbl.push_back('{4'b0100, 10, 4'b0001, 4'b0000, 4'b0000, 1'b1});
    tbl.push_back('{4'b0100,  1, 4'b0100, 4'b0100, 4'b0001, 1'b0});
    tbl.push_back('{4'b0100,  1, 4'b0100, 4'b0000, 4'b0000, 1'b0});
    tbl.push_back('{4'b0110,  5, 4'b0100, 4'b0000, 4'b0000, 1'b1});
    tbl.push_back('{4'b0100, 11, 4'b0100, 4'b0000, 4'b0000, 1'b0});
    tbl.push_back('{4'b1100,  4, 4'b0100, 4'b0000, 4'b0000, 1'b1});
    tbl.push_back('{4'b1110, 10, 4'b0100, 4'b0000, 4'b0000, 1'b1});
    tbl.push_back('{4'b1110,  1, 4'b1110, 4'b1010, 4'b0000, 1'b0});
    tbl.push_back('{4'b1110,  1, 4'b1110, 4'b0000, 4'b0000, 1'b0});

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      raw = tbl[i].raw;
      for (int unsigned c = 0; c < tbl[i].n; c++) tick();
      check($sformatf("tbl%0d.db", i),   db,   tbl[i].db);
      check($sformatf("tbl%0d.rise", i), rise, tbl[i].rise);
      check($sformatf("tbl%0d.fall", i), fall, tbl[i].fall);
      check($sformatf("tbl%0d.busy", i), {3'b000, busy}, {3'b000, tbl[i].busy});
    end

    // Bounce on bit0: 1,0,1 every 3 cycles, then hold 1; exactly one rise.
    rise_cnt = 0;
    raw = 4'b1111; repeat (3) begin tick(); if (rise != 0) rise_cnt++; end
    raw = 4'b1110; repeat (3) begin tick(); if (rise != 0) rise_cnt++; end
    raw = 4'b1111;
    repeat (10) begin
      tick();
      if (rise != 0) rise_cnt++;
      check("bounce.hold_db", db, 4'b1110);
    end
    tick();
    if (rise != 0) rise_cnt++;
    check("bounce.db",   db,   4'b1111);
    check("bounce.rise", rise, 4'b0001);
    repeat (4) begin tick(); if (rise != 0) rise_cnt++; end
    check("bounce.pulses", 4'(rise_cnt), 4'd1);

    // Reset with an update pending at cnt=5, raw held through release.
    raw = 4'b0101;
    repeat (8) tick();
    check("pend.db",   db, 4'b1111);
    check("pend.busy", {3'b000, busy}, 4'b0001);
    apply_reset();
    repeat (10) tick();
    check("post_rst.db",   db, 4'b0000);
    check("post_rst.busy", {3'b000, busy}, 4'b0001);
    tick();
    check("post_rst.db_up", db,   4'b0101);
    check("post_rst.rise",  rise, 4'b0101);
    tick();
    check("post_rst.rise_clr", rise, 4'b0000);

    // Randomised segments against the model, with one reset in the middle.
    for (int seg = 0; seg < 60; seg++) begin
      if (seg == 30) begin
        @(posedge clk);
        apply_reset();
      end
      raw = N'($urandom_range(0, 15));
      repeat ($urandom_range(1, 14)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
